// File: rtl/motor_drive_control.sv
// ==== motor_drive_control: two-wheel H-bridge PWM drive with duty ramping and dead-time reversal ====
// Revision 1.0
`default_nettype none

module motor_drive_control #(
  parameter int PWM_PERIOD = 10_000,
  parameter int VEER_DUTY  = 7_500,
  parameter int HARD_DUTY  = 2_500,
  parameter int RAMP_STEP  = 1_000,
  parameter int DEAD_TIME  = 5_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] DIR,
  input  logic       direction,
  output logic       L_PWM,
  output logic       R_PWM,
  output logic       L_FWD,
  output logic       R_FWD,
  output logic [3:0] wheelState
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    DEAD    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam logic [13:0] FULL  = 14'(PWM_PERIOD);
  localparam logic [13:0] LAST  = 14'(PWM_PERIOD - 1);
  localparam logic [13:0] VEER  = (VEER_DUTY > PWM_PERIOD) ? FULL : 14'(VEER_DUTY);
  localparam logic [13:0] HARD  = (HARD_DUTY > PWM_PERIOD) ? FULL : 14'(HARD_DUTY);
  localparam logic [13:0] STEP  = 14'(RAMP_STEP);
  localparam int          DW    = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TIME - 1);

  logic [13:0]   cnt;
  logic          boundary;
  logic [13:0]   base_l, base_r;
  logic          base_lf, base_rf;
  logic          stop;
  logic [13:0]   tgt_duty [2];
  logic          tgt_fwd  [2];
  logic          mism     [2];
  state_t        st       [2];
  logic [13:0]   duty     [2];
  logic [DW-1:0] dead_cnt [2];
  logic          fwd      [2];
  logic          pwm      [2];

  assign boundary = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= boundary ? '0 : cnt + 14'd1;
  end

  // Base targets are in the forward frame; reversing travel swaps sides and flips rotation.
  always_comb begin
    base_l  = '0;
    base_r  = '0;
    base_lf = 1'b1;
    base_rf = 1'b1;
    stop    = 1'b0;
    case (DIR)
      4'b0000: begin base_l = FULL; base_r = FULL; end
      4'b1001: begin base_l = FULL; base_r = VEER; end
      4'b1010: begin base_l = FULL; base_r = HARD; end
      4'b1011: begin base_l = FULL; base_r = FULL; base_rf = 1'b0; end
      4'b0101: begin base_l = VEER; base_r = FULL; end
      4'b0110: begin base_l = HARD; base_r = FULL; end
      4'b0111: begin base_l = FULL; base_r = FULL; base_lf = 1'b0; end
      default: stop = 1'b1;
    endcase
    tgt_duty[0] = direction ? base_l : base_r;
    tgt_duty[1] = direction ? base_r : base_l;
    tgt_fwd[0]  = stop ? fwd[0] : (direction ? base_lf : ~base_rf);
    tgt_fwd[1]  = stop ? fwd[1] : (direction ? base_rf : ~base_lf);
  end

  for (genvar w = 0; w < 2; w++) begin : g_wheel
    logic [13:0] ramped;

    assign mism[w] = (tgt_fwd[w] != fwd[w]);

    // Step limited by the remaining distance, so the result never leaves [0, target range].
    always_comb begin
      ramped = tgt_duty[w];
      if (tgt_duty[w] > duty[w]) begin
        if (tgt_duty[w] - duty[w] > STEP) ramped = duty[w] + STEP;
      end else if (duty[w] - tgt_duty[w] > STEP) begin
        ramped = duty[w] - STEP;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st[w]       <= IDLE;
        duty[w]     <= '0;
        dead_cnt[w] <= '0;
        fwd[w]      <= 1'b1;
        pwm[w]      <= 1'b0;
      end else begin
        pwm[w] <= 1'b0;
        case (st[w])
          IDLE: begin
            duty[w] <= '0;
            if (boundary) begin
              if (mism[w]) begin
                st[w] <= DEAD;
              end else if (tgt_duty[w] != '0) begin
                st[w]   <= RUN;
                duty[w] <= ramped;
              end
            end
          end
          RUN: begin
            if (mism[w]) begin
              st[w]   <= DEAD;
              duty[w] <= '0;
            end else if (stop) begin
              st[w]   <= IDLE;
              duty[w] <= '0;
            end else begin
              pwm[w] <= (cnt < duty[w]);
              if (boundary) begin
                duty[w] <= ramped;
                if (ramped == '0 && tgt_duty[w] == '0) st[w] <= IDLE;
              end
            end
          end
          DEAD: begin
            duty[w] <= '0;
            if (dead_cnt[w] == DEAD_LAST) begin
              dead_cnt[w] <= '0;
              fwd[w]      <= ~fwd[w];
              st[w]       <= IDLE;
            end else begin
              dead_cnt[w] <= dead_cnt[w] + 1'b1;
            end
          end
          default: begin
            st[w]       <= IDLE;
            duty[w]     <= '0;
            dead_cnt[w] <= '0;
          end
        endcase
      end
    end
  end

  assign L_PWM      = pwm[0];
  assign R_PWM      = pwm[1];
  assign L_FWD      = fwd[0];
  assign R_FWD      = fwd[1];
  assign wheelState = {st[0], st[1]};

endmodule

`default_nettype wire

// File: doc/motor_drive_control.md
MOTOR_DRIVE_CONTROL -- requirements
Module: motor_drive_control

Interface
REQ-001 SHALL have parameter PWM_PERIOD, default 10_000, meaning clocks per PWM period (max 16383).
REQ-002 SHALL have parameter VEER_DUTY, default 7_500, meaning inner-wheel duty for VEER codes.
REQ-003 SHALL have parameter HARD_DUTY, default 2_500, meaning inner-wheel duty for HARD codes.
REQ-004 SHALL have parameter RAMP_STEP, default 1_000, meaning maximum duty change per PWM period.
REQ-005 SHALL have parameter DEAD_TIME, default 5_000, meaning clocks a wheel is held off before its rotation direction flips.
REQ-006 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port DIR  input  4  steering code from direction control (PROCEED 0000, VEER_RIGHT 1001, HARD_RIGHT 1010, NINETY_RIGHT 1011, VEER_LEFT 0101, HARD_LEFT 0110, NINETY_LEFT 0111, STOP 1111).
REQ-009 SHALL have port direction  input  1  travel direction, 1 = forwards, 0 = backwards.
REQ-010 SHALL have ports L_PWM, R_PWM  output  1 each  H-bridge enable per wheel.
REQ-011 SHALL have ports L_FWD, R_FWD  output  1 each  H-bridge rotation per wheel, 1 = forward.
REQ-012 SHALL have port wheelState  output  4  [3:2] left, [1:0] right wheel FSM state, for debug.

Function
REQ-013 SHALL run a 14-bit period counter 0..PWM_PERIOD-1, wrapping to 0; the cycle with count == PWM_PERIOD-1 is the period boundary.
REQ-014 SHALL decode DIR every clock into per-wheel target (duty, rotation): PROCEED both PWM_PERIOD fwd; VEER/HARD_RIGHT left PWM_PERIOD, right VEER_DUTY/HARD_DUTY, both fwd; NINETY_RIGHT left PWM_PERIOD fwd, right PWM_PERIOD reverse; LEFT codes mirrored; STOP and every undefined code both duty 0, rotation unchanged.
REQ-015 SHALL, when direction = 0, swap left/right targets and invert both target rotations.
REQ-016 SHALL drive x_PWM = 1 exactly when wheel state is RUN and count < applied duty; registered output, one clock after counter.
REQ-017 SHALL give each wheel an FSM: IDLE (00), RUN (01), DEAD (10); code 11 unused, recovers to IDLE.
REQ-018 IDLE: applied duty 0; at boundary, if target duty > 0 and target rotation == x_FWD, go RUN; if target rotation != x_FWD, go DEAD.
REQ-019 RUN: at each boundary applied duty moves toward target by min(|target-applied|, RAMP_STEP); if target rotation != x_FWD, go DEAD immediately (not waiting for boundary); if applied duty reaches 0 with target 0, go IDLE.
REQ-020 DEAD: applied duty 0, PWM low, dead counter counts DEAD_TIME clocks; on expiry toggle x_FWD, clear counter, go IDLE; target changes during DEAD do not restart the count.
REQ-021 SHALL treat DIR == STOP as priority: next clock both applied duties 0, both PWM low, RUN wheels go IDLE, DEAD wheels continue their count.
REQ-022 Simultaneous boundary and rotation mismatch: DEAD wins.
REQ-023 Applied duty SHALL saturate to [0, PWM_PERIOD]; no wrap-around from ramp arithmetic.

Reset
REQ-024 On rst = 0, asynchronously: counter 0, applied duties 0, dead counters 0, both wheels IDLE, L_PWM = R_PWM = 0, L_FWD = R_FWD = 1, wheelState = 0000.
REQ-025 Reset mid-period or mid-DEAD SHALL abort all activity; after release operation restarts from count 0 with rotation forward.

Verification
REQ-026 Bench params PWM_PERIOD=100, VEER_DUTY=75, HARD_DUTY=25, RAMP_STEP=25, DEAD_TIME=20 unless stated.
REQ-027 Reset released, DIR=PROCEED, direction=1 -> both duties 25,50,75,100 over four successive periods, L_FWD=R_FWD=1, PWM high 100/100 clocks in fourth period.
REQ-028 At full speed, DIR=HARD_RIGHT -> left stays 100, right 75,50,25 over three periods then holds 25 high clocks per period.
REQ-029 At full speed, DIR=NINETY_LEFT -> next clock left enters DEAD, L_PWM low 20 clocks, L_FWD goes 0, left ramps 25..100 reverse; right unchanged.
REQ-030 At full speed, DIR=STOP mid-period -> both PWM low next clock, both wheelState 00, FWD bits unchanged; DIR=0011 behaves identically.
REQ-031 direction 1->0 under PROCEED -> both wheels DEAD 20 clocks, both FWD=0, ramp up; rst pulsed low mid-DEAD -> all outputs reset values immediately, FWD=1.
